// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the memory lane sequencer.
// Contents:
//   N       default lane data width
//   ADDR_W  default memory address width
//   LANES   number of lanes walked per memory instruction
//   state_e sequencer FSM state encoding
package gpu_mem_pkg;

  localparam int N      = 18;
  localparam int ADDR_W = 19;
  localparam int LANES  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/lane_select.sv
// Combinational lane mux: picks the captured address and store data for the
// lane currently being issued.
// Ports:
//   lane_i  lane index (0..2); any other value selects zero
//   addr_i  per-lane memory addresses
//   data_i  per-lane store data
//   addr_o  selected address
//   data_o  selected store data
module lane_select #(
  parameter int N      = gpu_mem_pkg::N,
  parameter int ADDR_W = gpu_mem_pkg::ADDR_W
) (
  input  logic [1:0]             lane_i,
  input  logic [2:0][ADDR_W-1:0] addr_i,
  input  logic [2:0][N-1:0]      data_i,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [N-1:0]           data_o
);

  always_comb begin
    addr_o = '0;
    data_o = '0;
    case (lane_i)
      2'd0: begin
        addr_o = addr_i[0];
        data_o = data_i[0];
      end
      2'd1: begin
        addr_o = addr_i[1];
        data_o = data_i[1];
      end
      2'd2: begin
        addr_o = addr_i[2];
        data_o = data_i[2];
      end
      default: begin
        addr_o = '0;
        data_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_lane_sequencer.sv
// Memory lane sequencer: accepts one three-lane instruction at a time and,
// for loads/stores, walks lanes 0..2 over a single-port memory, one lane per
// cycle. ALU-only instructions complete the cycle after capture.
//
// Handshake: an instruction transfers on a rising clk edge where inValid=1
// and stall=0. stall is a pure function of the registered FSM state, so the
// upstream buffer may hold (load = ~stall) without a combinational loop.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   inValid               upstream instruction present
//   ALUResult, writeData  per-lane ALU results / store data
//   q1, q2, q3            lane 0/1/2 memory addresses
//   WA3, RegWrite,
//   MemtoReg, MemWrite    destination register and control bits
//   memAddr, memWData,
//   memWE, memRE          single-port memory request
//   memRData              read data, valid one cycle after memRE
//   stall                 upstream must hold
//   outValid              one-cycle completion pulse
//   readDataO, ALUResultO,
//   WA3O, RegWriteO,
//   MemtoRegO             completed instruction results (held between pulses)
//   dbg_state             current FSM state (IDLE/ACCESS/DRAIN encoding)
module mem_lane_sequencer #(
  parameter int N      = gpu_mem_pkg::N,
  parameter int ADDR_W = gpu_mem_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  input  logic [2:0][N-1:0]      ALUResult,
  input  logic [ADDR_W-1:0]      q1,
  input  logic [ADDR_W-1:0]      q2,
  input  logic [ADDR_W-1:0]      q3,
  input  logic [2:0][N-1:0]      writeData,
  input  logic [3:0]             WA3,
  input  logic                   RegWrite,
  input  logic                   MemtoReg,
  input  logic                   MemWrite,
  output logic [ADDR_W-1:0]      memAddr,
  output logic [N-1:0]           memWData,
  output logic                   memWE,
  output logic                   memRE,
  input  logic [N-1:0]           memRData,
  output logic                   stall,
  output logic                   outValid,
  output logic [2:0][N-1:0]      readDataO,
  output logic [2:0][N-1:0]      ALUResultO,
  output logic [3:0]             WA3O,
  output logic                   RegWriteO,
  output logic                   MemtoRegO,
  output logic [1:0]             dbg_state
);

  import gpu_mem_pkg::*;

  state_e state_q, state_d;
  logic [1:0] lane_q, lane_d;

  // Captured instruction
  logic [2:0][ADDR_W-1:0] cap_addr_q;
  logic [2:0][N-1:0]      cap_wdata_q;
  logic [2:0][N-1:0]      cap_alu_q;
  logic [3:0]             cap_wa3_q;
  logic                   cap_regwrite_q;
  logic                   cap_store_q;
  logic                   cap_load_q;
  // Read data for lanes 0 and 1; lane 2 arrives in DRAIN and goes straight out
  logic [1:0][N-1:0]      cap_rd_q;

  // Output registers
  logic                   out_valid_q;
  logic [2:0][N-1:0]      rd_o_q;
  logic [2:0][N-1:0]      alu_o_q;
  logic [3:0]             wa3_o_q;
  logic                   regwrite_o_q;
  logic                   memtoreg_o_q;

  logic accept;
  logic complete_alu;
  logic complete_mem;
  logic rd_cap_en;

  logic [ADDR_W-1:0] sel_addr;
  logic [N-1:0]      sel_wdata;

  assign accept = (state_q == IDLE) && inValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    complete_alu = 1'b0;
    complete_mem = 1'b0;
    rd_cap_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (inValid && (MemWrite || MemtoReg)) begin
          state_d = ACCESS;
          lane_d  = 2'd0;
        end else if (inValid) begin
          complete_alu = 1'b1;
        end
      end
      ACCESS: begin
        // Data for the previous lane's read is on memRData now
        if (!cap_store_q && (lane_q != 2'd0)) begin
          rd_cap_en = 1'b1;
        end
        if (lane_q == 2'(LANES - 1)) begin
          lane_d = 2'd0;
          if (cap_store_q) begin
            state_d      = IDLE;
            complete_mem = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          lane_d = lane_q + 2'd1;
        end
      end
      DRAIN: begin
        state_d      = IDLE;
        complete_mem = 1'b1;
      end
      default: begin
        state_d = IDLE;
        lane_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_addr_q     <= '0;
      cap_wdata_q    <= '0;
      cap_alu_q      <= '0;
      cap_wa3_q      <= '0;
      cap_regwrite_q <= 1'b0;
      cap_store_q    <= 1'b0;
      cap_load_q     <= 1'b0;
      cap_rd_q       <= '0;
      out_valid_q    <= 1'b0;
      rd_o_q         <= '0;
      alu_o_q        <= '0;
      wa3_o_q        <= '0;
      regwrite_o_q   <= 1'b0;
      memtoreg_o_q   <= 1'b0;
    end else begin
      if (accept) begin
        cap_addr_q[0]  <= q1;
        cap_addr_q[1]  <= q2;
        cap_addr_q[2]  <= q3;
        cap_wdata_q    <= writeData;
        cap_alu_q      <= ALUResult;
        cap_wa3_q      <= WA3;
        cap_regwrite_q <= RegWrite;
        // Store wins when both are set, so such an instruction never reads
        cap_store_q    <= MemWrite;
        cap_load_q     <= MemtoReg && !MemWrite;
      end
      if (rd_cap_en) begin
        // lane 1 -> slot 0, lane 2 -> slot 1
        cap_rd_q[lane_q[1]] <= memRData;
      end
      out_valid_q <= complete_alu || complete_mem;
      if (complete_alu) begin
        rd_o_q       <= '0;
        alu_o_q      <= ALUResult;
        wa3_o_q      <= WA3;
        regwrite_o_q <= RegWrite;
        memtoreg_o_q <= 1'b0;
      end
      if (complete_mem) begin
        rd_o_q       <= cap_store_q ? '0 : {memRData, cap_rd_q[1], cap_rd_q[0]};
        alu_o_q      <= cap_alu_q;
        wa3_o_q      <= cap_wa3_q;
        regwrite_o_q <= cap_regwrite_q;
        memtoreg_o_q <= cap_load_q;
      end
    end
  end

  lane_select #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_lane_select (
    .lane_i (lane_q),
    .addr_i (cap_addr_q),
    .data_i (cap_wdata_q),
    .addr_o (sel_addr),
    .data_o (sel_wdata)
  );

  // Memory port is quiet (all zero) outside ACCESS
  assign memAddr    = (state_q == ACCESS) ? sel_addr  : '0;
  assign memWData   = (state_q == ACCESS) ? sel_wdata : '0;
  assign memWE      = (state_q == ACCESS) &&  cap_store_q;
  assign memRE      = (state_q == ACCESS) && !cap_store_q;

  assign stall      = (state_q != IDLE);
  assign outValid   = out_valid_q;
  assign readDataO  = rd_o_q;
  assign ALUResultO = alu_o_q;
  assign WA3O       = wa3_o_q;
  assign RegWriteO  = regwrite_o_q;
  assign MemtoRegO  = memtoreg_o_q;
  assign dbg_state  = state_q;

endmodule
